// File: rtl/lfpm_serial_mult.sv
// lfpm_serial_mult: byte-serial Mitchell (logarithmic) approximate FP multiplier.
// Operands A/B arrive LSB byte first on two byte lanes, and the product leaves
// LSB byte first on the same kind of valid/ready handshake.
// Build option: define LFPM_ERR_COMP_EN to add the 2^-4 Mitchell error
// compensation term to the fraction sum. It applies only when both mantissas
// are nonzero.
module lfpm_serial_mult #(
    parameter int FP_W        = 16,
    parameter int EXP_W       = 5,
    parameter int MAN_W       = 10,
    parameter int PIPE_STAGES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a_byte,
    input  logic [7:0] b_byte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_byte,
    output logic       out_last,
    output logic [3:0] flags,
    output logic       busy
);

    localparam int NB   = FP_W / 8;
    localparam int CW   = $clog2(NB + 1);
    localparam int PW   = $clog2(PIPE_STAGES + 1);
    localparam int EW2  = EXP_W + 2;
    localparam int BIAS = 2 ** (EXP_W - 1) - 1;

    localparam logic signed [EW2-1:0] E_MAX  = EW2'(2 ** EXP_W - 1);
    localparam logic signed [EW2-1:0] E_ZERO = '0;
    localparam logic signed [EW2-1:0] E_BIAS = EW2'(BIAS);

    typedef enum logic [1:0] {IDLE, LOAD, COMP, SEND} state_t;

    state_t state, state_nx;

    logic [CW-1:0]   byte_cnt;
    logic [PW-1:0]   pipe_cnt;
    logic [FP_W-1:0] a_reg, b_reg, p_reg;
    logic [3:0]      flags_reg;

    logic in_fire, out_fire, last_beat, comp_done;

    // Arithmetic datapath signals
    logic                  sa, sb, sign;
    logic [EXP_W-1:0]      ea, eb;
    logic [MAN_W-1:0]      ma, mb, frac;
    logic [MAN_W+1:0]      m_sum;
    logic                  carry;
    logic signed [EW2-1:0] e_sum;
    logic                  a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [FP_W-1:0]       res_p;
    logic [3:0]            res_flags;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign last_beat = (byte_cnt == CW'(NB - 1));
    assign comp_done = (pipe_cnt == PW'(PIPE_STAGES - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (in_fire) state_nx = last_beat ? COMP : LOAD;
            LOAD: if (in_fire && last_beat) state_nx = COMP;
            COMP: if (comp_done) state_nx = SEND;
            SEND: if (out_fire && last_beat) state_nx = IDLE;
        endcase
    end

    // Handshake and output beat decode
    always_comb begin
        in_ready  = (state == IDLE) || (state == LOAD);
        out_valid = (state == SEND);
        out_byte  = out_valid ? p_reg[7:0] : '0;
        out_last  = out_valid && last_beat;
        flags     = out_valid ? flags_reg : '0;
        busy      = (state != IDLE);
    end

    // Operand capture, compute-latency count, product shift-out
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt  <= '0;
            pipe_cnt  <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            p_reg     <= '0;
            flags_reg <= '0;
        end else begin
            unique case (state)
                IDLE, LOAD: begin
                    pipe_cnt <= '0;
                    if (in_fire) begin
                        // Right-shifting load: after NB beats the first byte sits at [7:0]
                        a_reg    <= (a_reg >> 8) | (FP_W'(a_byte) << (FP_W - 8));
                        b_reg    <= (b_reg >> 8) | (FP_W'(b_byte) << (FP_W - 8));
                        byte_cnt <= last_beat ? '0 : byte_cnt + CW'(1);
                    end
                end
                COMP: begin
                    // Operands are frozen through COMP, so the result is captured on its last cycle
                    if (comp_done) begin
                        pipe_cnt  <= '0;
                        p_reg     <= res_p;
                        flags_reg <= res_flags;
                    end else begin
                        pipe_cnt <= pipe_cnt + PW'(1);
                    end
                end
                SEND: begin
                    if (out_fire) begin
                        p_reg    <= p_reg >> 8;
                        byte_cnt <= last_beat ? '0 : byte_cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    // Mitchell multiply with special-case priority: NaN, inf, zero, then arithmetic
    always_comb begin
        sa     = a_reg[FP_W-1];
        sb     = b_reg[FP_W-1];
        ea     = a_reg[MAN_W +: EXP_W];
        eb     = b_reg[MAN_W +: EXP_W];
        ma     = a_reg[MAN_W-1:0];
        mb     = b_reg[MAN_W-1:0];
        sign   = sa ^ sb;
        a_nan  = (&ea) && (|ma);
        b_nan  = (&eb) && (|mb);
        a_inf  = (&ea) && !(|ma);
        b_inf  = (&eb) && !(|mb);
        a_zero = (ea == '0);
        b_zero = (eb == '0);

        m_sum = {2'b00, ma} + {2'b00, mb};
`ifdef LFPM_ERR_COMP_EN
        if ((|ma) && (|mb)) m_sum = m_sum + (MAN_W+2)'(1 << (MAN_W - 4));
`endif
        carry = |m_sum[MAN_W+1:MAN_W];
        frac  = m_sum[MAN_W-1:0];
`ifdef LFPM_ERR_COMP_EN
        // Compensated sum can reach 2.0; pin the fraction at its maximum
        if (m_sum[MAN_W+1]) frac = '1;
`endif
        e_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - E_BIAS
              + $signed(EW2'(carry));

        res_p     = '0;
        res_flags = '0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            res_p[MAN_W +: EXP_W] = '1;
            res_p[MAN_W-1]        = 1'b1;
            res_flags[3]          = 1'b1;
        end else if (a_inf || b_inf) begin
            res_p[FP_W-1]         = sign;
            res_p[MAN_W +: EXP_W] = '1;
            res_flags[2]          = 1'b1;
        end else if (a_zero || b_zero) begin
            res_p[FP_W-1] = sign;
            res_flags[1]  = 1'b1;
        end else if (e_sum >= E_MAX) begin
            res_p[FP_W-1]         = sign;
            res_p[MAN_W +: EXP_W] = '1;
            res_flags[2]          = 1'b1;
        end else if (e_sum <= E_ZERO) begin
            res_p[FP_W-1] = sign;
            res_flags[1]  = 1'b1;
        end else begin
            res_p        = {sign, e_sum[EXP_W-1:0], frac};
            res_flags[0] = (|ma) && (|mb);
        end
    end

endmodule
